// File: rtl/instr_mem_loader.sv
// Program loader for the 2^20 x 16-bit instruction memory.
// Assembles big-endian 16-bit words from a byte stream and writes them to
// consecutive word addresses starting at a programmable base. The processor
// is held in stall (busy) for the duration of a load.
//
// Handshake: a byte is transferred on a rising clock edge where both
// byte_valid and byte_ready are 1. The source must hold byte_in stable while
// byte_valid=1 and byte_ready=0. byte_ready depends only on the loader's
// state, never on byte_valid.
module instr_mem_loader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  abort,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  writeEnable,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] words_written,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_HI = 3'd1,
        GET_LO = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] ww_next;

    // Count after the word in WRITE is committed; decides DONE vs. next word.
    assign ww_next = words_written + ADDR_WIDTH'(1);

    // Status outputs decode the registered state, so they are clean for a
    // whole cycle and writeEnable coincides exactly with the WRITE cycle.
    assign byte_ready  = (state == GET_HI) || (state == GET_LO);
    assign writeEnable = (state == WRITE);
    assign busy        = (state == GET_HI) || (state == GET_LO) || (state == WRITE);
    assign done        = (state == DONE);
    assign dbg_state   = state;

    // Load sequencer: capture the job, collect two bytes per word, present the
    // word for one write cycle, repeat until the count is reached or aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base_q        <= '0;
            count_q       <= '0;
            writeAddress  <= '0;
            writeData     <= '0;
            words_written <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q        <= base_addr;
                        count_q       <= word_count;
                        words_written <= '0;
                        state         <= (word_count != '0) ? GET_HI : DONE;
                    end
                end
                GET_HI: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (byte_valid) begin
                        writeData[15:8] <= byte_in;
                        state           <= GET_LO;
                    end
                end
                GET_LO: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (byte_valid) begin
                        writeData[7:0] <= byte_in;
                        // Address is fixed here so it is stable throughout WRITE;
                        // the addition wraps naturally at 2^ADDR_WIDTH.
                        writeAddress   <= base_q + words_written;
                        state          <= WRITE;
                    end
                end
                WRITE: begin
                    // The word is committed by the memory this cycle even if
                    // abort is raised, so it always counts.
                    words_written <= ww_next;
                    if (abort) begin
                        state <= IDLE;
                    end else if (ww_next == count_q) begin
                        state <= DONE;
                    end else begin
                        state <= GET_HI;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed loads, a write scoreboard fed from a
// word-level model, and literal expectations for selected writes.
module tb_instr_mem_loader;

  localparam int AW = 20;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic          abort;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] writeAddress;
  logic [DW-1:0] writeData;
  logic          writeEnable;
  logic          busy;
  logic          done;
  logic [AW-1:0] words_written;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .abort        (abort),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .writeEnable  (writeEnable),
    .busy         (busy),
    .done         (done),
    .words_written(words_written),
    .dbg_state    (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int busy_cnt = 0;

  logic [AW+DW-1:0] exp_q[$];    // expected {addr,data} writes, in order
  logic [AW+DW-1:0] act_log[$];  // every observed write
  int               we_cyc[$];   // cycle of every observed write
  int               done_cyc[$]; // cycle of every observed done pulse
  logic [7:0]       src_q[$];    // bytes for the next load

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (writeEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h@%h required=no_write", writeData, writeAddress);
      end else begin
        check("write_addr_data", {writeAddress, writeData}, exp_q.pop_front());
      end
      act_log.push_back({writeAddress, writeData});
      we_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      check("done_not_busy", busy, 1'b0);
    end
    if (busy === 1'b1) busy_cnt++;
    if (byte_ready === 1'b1) check("ready_implies_busy", busy, 1'b1);
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout actual=0 required=1");
    end
    @(negedge clk);
  endtask

  // Word-level model: word i of the load is bytes 2i,2i+1 (big-endian) at base+i mod 2^20.
  task automatic model_load(input logic [AW-1:0] base, input int cnt);
    for (int i = 0; i < cnt; i++)
      exp_q.push_back({AW'(base + AW'(i)), src_q[2*i], src_q[2*i+1]});
  endtask

  task automatic run_load(input logic [AW-1:0] base, input int cnt, input int gap_max,
                          input bit poke_start);
    int nd0, nw0, b0, c0, dc, t;
    nd0 = done_cyc.size();
    nw0 = we_cyc.size();
    b0  = busy_cnt;
    c0  = cyc;
    model_load(base, cnt);
    start      = 1'b1;
    base_addr  = base;
    word_count = AW'(cnt);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2*cnt; i++) begin
      if (poke_start && i == 1) begin
        start      = 1'b1;
        base_addr  = 20'h00700;
        word_count = 20'd5;
      end
      send_byte(src_q[i], (gap_max > 0) ? $urandom_range(gap_max, 0) : 0);
      start = 1'b0;
    end
    byte_valid = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1'b1);
    dc = cyc;
    check("words_written", words_written, AW'(cnt));
    check("exp_q_drained", exp_q.size(), 0);
    check("write_count", we_cyc.size() - nw0, cnt);
    if (cnt > 0) check("done_after_last_write", dc - we_cyc[$], 1);
    if (gap_max == 0)
      for (int i = nw0 + 1; i < we_cyc.size(); i++)
        check("write_spacing", we_cyc[i] - we_cyc[i-1], 3);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("done_pulse_count", done_cyc.size() - nd0, 1);
    check("busy_cycles", busy_cnt - b0, dc - c0 - 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nw0, nd0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_we", writeEnable, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", writeAddress, '0);
    check("rst_data", writeData, '0);
    check("rst_words", words_written, '0);
    rst = 1'b0;
    @(negedge clk);

    // Basic two-word load, back-to-back bytes.
    src_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    nw0 = act_log.size();
    run_load(20'h00010, 2, 0, 1'b0);
    check("lit_word0", act_log[nw0],   36'h00010_1234);
    check("lit_word1", act_log[nw0+1], 36'h00011_ABCD);
    check("lit_words_written", words_written, 20'd2);

    // Four words with random source gaps.
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    nw0 = act_log.size();
    run_load(20'h00200, 4, 3, 1'b0);
    check("lit_gap_word3", act_log[nw0+3], 36'h00203_7788);

    // Address wrap.
    src_q = '{8'h00, 8'h01, 8'h00, 8'h02};
    nw0 = act_log.size();
    run_load(20'hFFFFF, 2, 0, 1'b0);
    check("lit_wrap0", act_log[nw0],   36'hFFFFF_0001);
    check("lit_wrap1", act_log[nw0+1], 36'h00000_0002);

    // Empty load.
    src_q.delete();
    run_load(20'h00005, 0, 0, 1'b0);

    // Abort after the high byte of word 2.
    src_q = '{8'hA1, 8'hB2, 8'hC3};
    nd0 = done_cyc.size();
    model_load(20'h00300, 1);
    start = 1'b1; base_addr = 20'h00300; word_count = 20'd3;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(src_q[i], 0);
    byte_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_ready", byte_ready, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_words", words_written, 20'd1);
    check("abort_exp_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cyc.size() - nd0, 0);
    src_q = '{8'h5A, 8'hA5};
    run_load(20'h00400, 1, 0, 1'b0);

    // Abort during WRITE: that write still happens and counts.
    src_q = '{8'h01, 8'h02};
    nd0 = done_cyc.size();
    nw0 = we_cyc.size();
    model_load(20'h00500, 1);
    start = 1'b1; base_addr = 20'h00500; word_count = 20'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) send_byte(src_q[i], 0);
    byte_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_wr_count", we_cyc.size() - nw0, 1);
    check("abort_wr_words", words_written, 20'd1);
    check("abort_wr_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_wr_no_done", done_cyc.size() - nd0, 0);

    // start during busy is ignored.
    src_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_load(20'h00600, 2, 0, 1'b1);

    // Reset in GET_LO mid-load.
    src_q = '{8'hEE, 8'h99};
    nw0 = we_cyc.size();
    start = 1'b1; base_addr = 20'h00800; word_count = 20'd2;
    @(negedge clk);
    start = 1'b0;
    send_byte(src_q[0], 0);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_in = src_q[1];
    @(negedge clk);
    rst = 1'b0;
    byte_valid = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", byte_ready, 1'b0);
    check("midrst_we", writeEnable, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_addr", writeAddress, '0);
    check("midrst_data", writeData, '0);
    check("midrst_words", words_written, '0);
    repeat (2) @(negedge clk);
    check("midrst_no_write", we_cyc.size() - nw0, 0);

    // Recovery load after reset.
    src_q = '{8'hC0, 8'hDE};
    nw0 = act_log.size();
    run_load(20'h00900, 1, 0, 1'b0);
    check("lit_recover", act_log[nw0], 36'h00900_C0DE);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
